wshb_frame_reader: RTL and testbench

- Wishbone master that fetches a frame buffer from SDRAM through the FPGA bridge (its wshb slave side), word by word, in bursts.
- Buffers the fetched pixels in an internal FIFO.
- Presents the pixels as a valid/ready stream to the video timing/output stage.
- Sits directly upstream of the bridge's Wishbone slave port; the frame base is the same img_addr the bridge receives.

---
 rtl/gfx_pkg.sv | 14 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/wshb_frame_reader.sv | 150 +++++++++++++++
 tb/tb_wshb_frame_reader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types and constants for the frame-buffer reader.
package gfx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    READ,
    FRAME_END
  } state_t;

  localparam logic [3:0]  WSHB_SEL_ALL   = 4'hF;
  localparam logic [31:0] BYTES_PER_WORD = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_wr;
  logic                  do_rd;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge sys_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone read master streaming a frame buffer into a pixel FIFO in reserved-space bursts.
//   state      | meaning
//   IDLE       | not fetching; waits for run
//   WAIT_SPACE | waits until the whole next burst fits in the FIFO
//   READ       | cyc/stb held, one word per ack
//   FRAME_END  | frame complete; restart or go idle depending on run
module wshb_frame_reader
  import gfx_pkg::*;
#(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST_LEN  = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        run,
  input  logic [31:0] img_addr,
  output logic        busy,
  output logic        frame_done,
  output logic        wshb_cyc_o,
  output logic        wshb_stb_o,
  output logic        wshb_we_o,
  output logic [3:0]  wshb_sel_o,
  output logic [31:0] wshb_adr_o,
  input  logic [31:0] wshb_dat_i,
  input  logic        wshb_ack_i,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int NWORDS = HDISP * VDISP;
  localparam int WL_W   = $clog2(NWORDS + 1);
  localparam int BL_W   = $clog2(BURST_LEN + 1);
  localparam int FC_W   = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [BL_W-1:0]   burst_left_q, burst_left_d;
  logic              cyc_q, cyc_d;
  logic              frame_done_q, frame_done_d;

  logic [FC_W-1:0]   fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              ack_hit;
  logic [31:0]       burst_len;
  logic [31:0]       free_slots;

  assign ack_hit   = (state_q == READ) && cyc_q && wshb_ack_i;
  assign burst_len = (32'(words_left_q) < 32'(BURST_LEN)) ? 32'(words_left_q) : 32'(BURST_LEN);
  // Registered count only: a pop this cycle is credited next cycle.
  assign free_slots = fifo_full ? 32'd0 : (32'(FIFO_DEPTH) - 32'(fifo_count));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      words_left_q <= '0;
      burst_left_q <= '0;
      cyc_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      words_left_q <= words_left_d;
      burst_left_q <= burst_left_d;
      cyc_q        <= cyc_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    words_left_d = words_left_q;
    burst_left_d = burst_left_q;
    cyc_d        = cyc_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          adr_d        = img_addr;
          words_left_d = WL_W'(NWORDS);
          state_d      = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (free_slots >= burst_len) begin
          cyc_d        = 1'b1;
          burst_left_d = BL_W'(burst_len);
          state_d      = READ;
        end
      end
      READ: begin
        if (ack_hit) begin
          adr_d        = adr_q + BYTES_PER_WORD;
          words_left_d = words_left_q - WL_W'(1);
          burst_left_d = burst_left_q - BL_W'(1);
          if (burst_left_q == BL_W'(1)) begin
            cyc_d = 1'b0;
            if (words_left_q == WL_W'(1)) begin
              frame_done_d = 1'b1;
              state_d      = FRAME_END;
            end else begin
              state_d = WAIT_SPACE;
            end
          end
        end
      end
      FRAME_END: begin
        if (run) begin
          adr_d        = img_addr;
          words_left_d = WL_W'(NWORDS);
          state_d      = WAIT_SPACE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (ack_hit),
    .wr_data (wshb_dat_i),
    .rd_en   (pix_valid && pix_ready),
    .rd_data (pix_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign wshb_cyc_o = cyc_q;
  assign wshb_stb_o = cyc_q;
  assign wshb_we_o  = 1'b0;
  assign wshb_sel_o = WSHB_SEL_ALL;
  assign wshb_adr_o = adr_q;
  assign pix_valid  = !fifo_empty;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Bench: 16-word frame instance (A) with memory model and pixel scoreboard; 10-word instance (B) for short last burst.
module tb_wshb_frame_reader;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst;
  logic        run_a, busy_a, fd_a, cyc_a, stb_a, we_a, ack_a, pv_a, pr_a;
  logic [3:0]  sel_a;
  logic [31:0] img_a, adr_a, dat_a, pd_a;
  logic        run_b, busy_b, fd_b, cyc_b, stb_b, we_b, ack_b, pv_b, pr_b;
  logic [3:0]  sel_b;
  logic [31:0] img_b, adr_b, dat_b, pd_b;

  wshb_frame_reader #(.HDISP(8), .VDISP(2), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run_a), .img_addr(img_a),
    .busy(busy_a), .frame_done(fd_a), .wshb_cyc_o(cyc_a), .wshb_stb_o(stb_a),
    .wshb_we_o(we_a), .wshb_sel_o(sel_a), .wshb_adr_o(adr_a), .wshb_dat_i(dat_a),
    .wshb_ack_i(ack_a), .pix_data(pd_a), .pix_valid(pv_a), .pix_ready(pr_a));

  wshb_frame_reader #(.HDISP(5), .VDISP(2), .BURST_LEN(4), .FIFO_DEPTH(8)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run_b), .img_addr(img_b),
    .busy(busy_b), .frame_done(fd_b), .wshb_cyc_o(cyc_b), .wshb_stb_o(stb_b),
    .wshb_we_o(we_b), .wshb_sel_o(sel_b), .wshb_adr_o(adr_b), .wshb_dat_i(dat_b),
    .wshb_ack_i(ack_b), .pix_data(pd_b), .pix_valid(pv_b), .pix_ready(pr_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  // Instance A models: slave memory, address expectation, pixel scoreboard
  logic        slave_en = 1'b1;
  int          ack_delay = 0;
  int          wcnt = 0;
  int          fw_a = 0;
  int          acks_a = 0;
  int          pix_cnt_a = 0;
  int          fd_cnt_a = 0;
  int          rdy_mode = 0;
  int          credit = 0;
  logic [31:0] exp_adr = 32'h0;
  logic [31:0] sb[$];

  always @(negedge sys_clk) begin
    if (slave_en) begin
      if (wcnt > 0) begin
        total++;
        if (!(cyc_a && stb_a)) begin
          bad++;
          $display("FAIL stb_hold: cyc=%b stb=%b required 1 while waiting for ack", cyc_a, stb_a);
        end
      end
      if (cyc_a && stb_a) begin
        if (wcnt >= ack_delay) begin
          chk("ack_adr", adr_a, exp_adr);
          ack_a = 1'b1;
          dat_a = mem_word(adr_a);
          sb.push_back(dat_a);
          acks_a++;
          exp_adr = exp_adr + 32'd4;
          fw_a++;
          if (fw_a == 16) begin
            fw_a    = 0;
            exp_adr = img_a;
          end
          wcnt = 0;
        end else begin
          ack_a = 1'b0;
          wcnt++;
        end
      end else begin
        ack_a = 1'b0;
        wcnt  = 0;
      end
    end
  end

  always @(negedge sys_clk) begin
    logic [31:0] e;
    case (rdy_mode)
      0:       pr_a = 1'b1;
      1:       pr_a = 1'b0;
      2:       pr_a = 1'($urandom_range(0, 1));
      default: pr_a = (credit > 0);
    endcase
    if (pv_a && pr_a) begin
      if (sb.size() == 0) begin
        chk("pix_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("pix_data", pd_a, e);
      end
      pix_cnt_a++;
      if (rdy_mode == 3) credit--;
    end
    if (fd_a) fd_cnt_a++;
  end

  // Instance B: ack every cycle, record cyc run lengths
  int acks_b = 0;
  int fd_cnt_b = 0;
  int cur_len = 0;
  int blen[$];

  always @(negedge sys_clk) begin
    if (cyc_b && stb_b) begin
      ack_b = 1'b1;
      dat_b = 32'(acks_b);
      acks_b++;
      cur_len++;
    end else begin
      ack_b = 1'b0;
      if (cur_len > 0) begin
        blen.push_back(cur_len);
        cur_len = 0;
      end
    end
    if (fd_b) begin
      chk("b_fd_after_10th_ack", 32'(acks_b), 32'd10);
      fd_cnt_b++;
    end
  end

  task reset_models();
    sb.delete();
    acks_a    = 0;
    pix_cnt_a = 0;
    fd_cnt_a  = 0;
    wcnt      = 0;
    fw_a      = 0;
    exp_adr   = img_a;
  endtask

  task start_frame();
    sys_rst  = 1'b0;
    run_a    = 1'b0;
    ack_a    = 1'b0;
    slave_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset_models();
    sys_rst = 1'b1;
    run_a   = 1'b1;
  endtask

  task drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge sys_clk);
  endtask

  typedef struct {
    int          adv;
    logic        run;
    logic        cyc;
    logic [31:0] adr;
    logic        busy;
    logic        fd;
  } vec_t;

  vec_t vecs[13];
  int   exp_blen[3];

  initial begin
    // edge-by-edge timeline after reset release, ack every cycle, pix_ready=1
    vecs[0]  = '{0, 1'b1, 1'b0, 32'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0};
    vecs[2]  = '{1, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[3]  = '{1, 1'b1, 1'b1, 32'h1004, 1'b1, 1'b0};
    vecs[4]  = '{3, 1'b1, 1'b0, 32'h1010, 1'b1, 1'b0};
    vecs[5]  = '{1, 1'b1, 1'b1, 32'h1010, 1'b1, 1'b0};
    vecs[6]  = '{4, 1'b1, 1'b0, 32'h1020, 1'b1, 1'b0};
    vecs[7]  = '{1, 1'b1, 1'b1, 32'h1020, 1'b1, 1'b0};
    vecs[8]  = '{4, 1'b1, 1'b0, 32'h1030, 1'b1, 1'b0};
    vecs[9]  = '{1, 1'b1, 1'b1, 32'h1030, 1'b1, 1'b0};
    vecs[10] = '{4, 1'b1, 1'b0, 32'h1040, 1'b1, 1'b1};
    vecs[11] = '{1, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0};
    vecs[12] = '{1, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0};
    exp_blen[0] = 4; exp_blen[1] = 4; exp_blen[2] = 2;

    sys_rst = 1'b0; run_a = 1'b0; run_b = 1'b0;
    img_a = 32'h1000; img_b = 32'h0;
    ack_a = 1'b0; dat_a = '0; ack_b = 1'b0; dat_b = '0;
    pr_a = 1'b1; pr_b = 1'b1;

    // 1: nominal streaming, two frames, burst timing table
    run_b = 1'b1;
    start_frame();
    for (int i = 0; i < 13; i++) begin
      repeat (vecs[i].adv) @(negedge sys_clk);
      chk($sformatf("t1_row%0d_cyc", i), 32'(cyc_a), 32'(vecs[i].cyc));
      chk($sformatf("t1_row%0d_stb", i), 32'(stb_a), 32'(vecs[i].cyc));
      chk($sformatf("t1_row%0d_adr", i), adr_a, vecs[i].adr);
      chk($sformatf("t1_row%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
      chk($sformatf("t1_row%0d_fd", i), 32'(fd_a), 32'(vecs[i].fd));
      run_a = vecs[i].run;
      if (i == 2) run_b = 1'b0;
    end
    chk("t1_we", 32'(we_a), 32'd0);
    chk("t1_sel", 32'(sel_a), 32'hF);
    for (int k = 0; k < 200 && fd_cnt_a < 2; k++) @(negedge sys_clk);
    drain();
    repeat (5) @(negedge sys_clk);
    chk("t1_fd_cnt", 32'(fd_cnt_a), 32'd2);
    chk("t1_acks", 32'(acks_a), 32'd32);
    chk("t1_pix_cnt", 32'(pix_cnt_a), 32'd32);
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("b_nbursts", 32'(blen.size()), 32'd3);
    for (int i = 0; i < 3 && i < blen.size(); i++)
      chk($sformatf("b_burst%0d_len", i), 32'(blen[i]), 32'(exp_blen[i]));
    chk("b_acks", 32'(acks_b), 32'd10);
    chk("b_fd_cnt", 32'(fd_cnt_b), 32'd1);

    // 2: consumer stalled, FIFO fills after two bursts, then 4 credits
    rdy_mode = 1;
    img_a = 32'h1000;
    start_frame();
    repeat (30) @(negedge sys_clk);
    chk("t2_acks_full", 32'(acks_a), 32'd8);
    chk("t2_cyc_full", 32'(cyc_a), 32'd0);
    chk("t2_pv_full", 32'(pv_a), 32'd1);
    chk("t2_pix_none", 32'(pix_cnt_a), 32'd0);
    credit = 4;
    rdy_mode = 3;
    repeat (20) @(negedge sys_clk);
    chk("t2_pix_4", 32'(pix_cnt_a), 32'd4);
    chk("t2_acks_12", 32'(acks_a), 32'd12);
    chk("t2_cyc_refull", 32'(cyc_a), 32'd0);
    rdy_mode = 0;
    run_a = 1'b0;
    for (int k = 0; k < 200 && fd_cnt_a < 1; k++) @(negedge sys_clk);
    drain();
    repeat (3) @(negedge sys_clk);
    chk("t2_pix_16", 32'(pix_cnt_a), 32'd16);
    chk("t2_acks_16", 32'(acks_a), 32'd16);
    chk("t2_busy", 32'(busy_a), 32'd0);

    // 3: run dropped mid-frame completes the frame then idles
    start_frame();
    for (int k = 0; k < 100 && acks_a < 6; k++) @(negedge sys_clk);
    run_a = 1'b0;
    for (int k = 0; k < 200 && fd_cnt_a < 1; k++) @(negedge sys_clk);
    repeat (20) @(negedge sys_clk);
    chk("t3_acks", 32'(acks_a), 32'd16);
    chk("t3_fd_cnt", 32'(fd_cnt_a), 32'd1);
    chk("t3_busy", 32'(busy_a), 32'd0);
    chk("t3_cyc", 32'(cyc_a), 32'd0);
    chk("t3_pix", 32'(pix_cnt_a), 32'd16);

    // 4: slow slave, random consumer, address wrap, img_addr change mid-frame
    ack_delay = 3;
    rdy_mode  = 2;
    img_a = 32'hFFFF_FFE0;
    start_frame();
    for (int k = 0; k < 400 && acks_a < 5; k++) @(negedge sys_clk);
    img_a = 32'h0000_3000;
    for (int k = 0; k < 2000 && acks_a < 20; k++) @(negedge sys_clk);
    run_a = 1'b0;
    for (int k = 0; k < 2000 && fd_cnt_a < 2; k++) @(negedge sys_clk);
    drain();
    repeat (3) @(negedge sys_clk);
    chk("t4_fd_cnt", 32'(fd_cnt_a), 32'd2);
    chk("t4_acks", 32'(acks_a), 32'd32);
    chk("t4_pix", 32'(pix_cnt_a), 32'd32);
    chk("t4_busy", 32'(busy_a), 32'd0);
    ack_delay = 0;

    // 5: reset mid-READ with a late ack
    rdy_mode = 1;
    img_a = 32'h1000;
    start_frame();
    for (int k = 0; k < 50 && acks_a < 2; k++) @(negedge sys_clk);
    sys_rst  = 1'b0;
    slave_en = 1'b0;
    ack_a    = 1'b1;
    @(negedge sys_clk);
    chk("t5_cyc_rst", 32'(cyc_a), 32'd0);
    chk("t5_stb_rst", 32'(stb_a), 32'd0);
    chk("t5_pv_rst", 32'(pv_a), 32'd0);
    chk("t5_adr_rst", adr_a, 32'h0);
    chk("t5_busy_rst", 32'(busy_a), 32'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t5_pv_late_ack", 32'(pv_a), 32'd0);
    chk("t5_cyc_late_ack", 32'(cyc_a), 32'd0);
    chk("t5_adr_restart", adr_a, 32'h1000);
    ack_a = 1'b0;
    reset_models();
    slave_en = 1'b1;
    rdy_mode = 0;
    run_a = 1'b0;
    for (int k = 0; k < 200 && fd_cnt_a < 1; k++) @(negedge sys_clk);
    drain();
    repeat (3) @(negedge sys_clk);
    chk("t5_pix", 32'(pix_cnt_a), 32'd16);
    chk("t5_acks", 32'(acks_a), 32'd16);
    chk("t5_fd_cnt", 32'(fd_cnt_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
